// File: rtl/ah_pl2ddr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ah_pl2ddr_pkg : shared types and constants for the PL-to-DDR capture path
// Rev 1.0
// ---------------------------------------------------------------------------
package ah_pl2ddr_pkg;

  localparam int WORD_BYTES         = 4;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } capture_state_t;

endpackage
`default_nettype wire

// File: rtl/ah_pl2ddr_word_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ah_pl2ddr_word_fifo : first-word-fall-through word buffer with flush
// Rev 1.0
// ---------------------------------------------------------------------------
module ah_pl2ddr_word_fifo
  import ah_pl2ddr_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push && (!full || do_pop) && !flush;
  assign drop    = push && full && !do_pop && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/ah_pl2ddr_capture_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ah_pl2ddr_capture_ctrl : sequences one ah_pl2ddr collector and streams its
// words to the DDR writer. Option: AH_PL2DDR_CTRL_DROPCNT_EN (drop counter).
// Rev 1.0
// ---------------------------------------------------------------------------
module ah_pl2ddr_capture_ctrl
  import ah_pl2ddr_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] sample_count,
  input  logic [31:0] undersampling_cfg,
  input  logic [31:0] base_addr,
  output logic        col_rst,
  output logic        col_data_en,
  output logic        col_fill_data,
  output logic [31:0] col_undersampling,
  input  logic [31:0] col_data_out,
  input  logic        col_data_valid,
  input  logic [31:0] col_data_index,
  input  logic [5:0]  col_data_pending,
  output logic [31:0] wr_data,
  output logic [31:0] wr_addr,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        aborted,
  output logic [31:0] words_written,
  output logic [15:0] dropped_words
);

  capture_state_t state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [31:0] us_q, us_d;
  logic [31:0] base_q, base_d;
  logic [31:0] words_q, words_d;
  logic        overflow_q, overflow_d;
  logic        aborted_q, aborted_d;
  logic        abort_rst_q, abort_rst_d;
  logic        clear_pulse;
  logic        start_accept, abort_accept;
  logic        fifo_empty, fifo_full, fifo_drop, fifo_pop;

  assign start_accept = (state_q == ST_IDLE) && start;
  assign abort_accept = (state_q != ST_IDLE) && abort;
  assign fifo_pop     = wr_valid && wr_ready;

  ah_pl2ddr_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort_accept),
    .push      (col_data_valid),
    .push_data (col_data_out),
    .pop       (fifo_pop),
    .pop_data  (wr_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    us_d          = us_q;
    base_d        = base_q;
    words_d       = words_q;
    overflow_d    = overflow_q;
    aborted_d     = aborted_q;
    abort_rst_d   = 1'b0;
    clear_pulse   = 1'b0;
    col_data_en   = 1'b0;
    col_fill_data = 1'b0;
    done          = 1'b0;

    if (fifo_pop)  words_d    = words_q + 32'd1;
    if (fifo_drop) overflow_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d    = sample_count;
          us_d       = undersampling_cfg;
          base_d     = base_addr;
          words_d    = '0;
          overflow_d = 1'b0;
          aborted_d  = 1'b0;
          state_d    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clear_pulse = 1'b1;
        state_d     = (count_q == '0) ? ST_DONE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        col_data_en = (col_data_index != count_q);
        if (col_data_index == count_q)
          state_d = (col_data_pending == '0) ? ST_DRAIN : ST_FLUSH;
      end
      ST_FLUSH: begin
        // Pad only while the word is incomplete so no extra sample is taken
        col_data_en   = (col_data_pending != '0);
        col_fill_data = 1'b1;
        if (col_data_pending == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty && !col_data_valid) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_accept) begin
      state_d       = ST_IDLE;
      abort_rst_d   = 1'b1;
      aborted_d     = 1'b1;
      col_data_en   = 1'b0;
      col_fill_data = 1'b0;
      done          = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      us_q        <= '0;
      base_q      <= '0;
      words_q     <= '0;
      overflow_q  <= 1'b0;
      aborted_q   <= 1'b0;
      abort_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      us_q        <= us_d;
      base_q      <= base_d;
      words_q     <= words_d;
      overflow_q  <= overflow_d;
      aborted_q   <= aborted_d;
      abort_rst_q <= abort_rst_d;
    end
  end

`ifdef AH_PL2DDR_CTRL_DROPCNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (start_accept)
      drop_cnt_d = '0;
    else if (fifo_drop && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign dropped_words = drop_cnt_q;
`else
  assign dropped_words = '0;
`endif

  assign col_rst           = clear_pulse || abort_rst_q;
  assign col_undersampling = us_q;
  assign wr_valid          = !fifo_empty;
  assign wr_addr           = base_q + (words_q * 32'(WORD_BYTES));
  assign busy              = (state_q != ST_IDLE);
  assign overflow          = overflow_q;
  assign aborted           = aborted_q;
  assign words_written     = words_q;

endmodule
`default_nettype wire

// File: tb/tb_ah_pl2ddr_capture_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ah_pl2ddr_capture_ctrl : directed bench with an 8-bit collector model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ah_pl2ddr_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, wr_ready;
  logic [31:0] sample_count, undersampling_cfg, base_addr;
  logic        col_rst, col_data_en, col_fill_data;
  logic [31:0] col_undersampling;
  logic [31:0] col_data_out;
  logic        col_data_valid;
  logic [31:0] col_data_index;
  logic [5:0]  col_data_pending;
  logic [31:0] wr_data, wr_addr, words_written;
  logic        wr_valid, busy, done, overflow, aborted;
  logic [15:0] dropped_words;

  int tests = 0;
  int fails = 0;

  // Monitor-owned history; tasks only read it
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          done_cnt  = 0;
  int          flush_cnt = 0;

`ifdef AH_PL2DDR_CTRL_DROPCNT_EN
  localparam logic [15:0] EXP_DROPPED = 16'd6;
`else
  localparam logic [15:0] EXP_DROPPED = 16'd0;
`endif

  always #5 clk = ~clk;

  ah_pl2ddr_capture_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .sample_count      (sample_count),
    .undersampling_cfg (undersampling_cfg),
    .base_addr         (base_addr),
    .col_rst           (col_rst),
    .col_data_en       (col_data_en),
    .col_fill_data     (col_fill_data),
    .col_undersampling (col_undersampling),
    .col_data_out      (col_data_out),
    .col_data_valid    (col_data_valid),
    .col_data_index    (col_data_index),
    .col_data_pending  (col_data_pending),
    .wr_data           (wr_data),
    .wr_addr           (wr_addr),
    .wr_valid          (wr_valid),
    .wr_ready          (wr_ready),
    .busy              (busy),
    .done              (done),
    .overflow          (overflow),
    .aborted           (aborted),
    .words_written     (words_written),
    .dropped_words     (dropped_words)
  );

  // Collector model: DATA_WIDTH=8, sample value 0x10+index, pad value 0, first sample in LSB
  logic [1:0]  m_fill;
  logic [31:0] m_word, m_next;
  logic [7:0]  m_sample;

  assign col_data_pending = (m_fill == 2'd0) ? 6'd0 : 6'(32 - 8 * int'(m_fill));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      col_data_index <= '0;
      m_fill         <= '0;
      m_word         <= '0;
      col_data_valid <= 1'b0;
      col_data_out   <= '0;
    end else begin
      col_data_valid <= 1'b0;
      if (col_rst) begin
        col_data_index <= '0;
        m_fill         <= '0;
        m_word         <= '0;
      end else if (col_data_en) begin
        m_sample = col_fill_data ? 8'h00 : (8'h10 + col_data_index[7:0]);
        m_next   = m_word | ({24'd0, m_sample} << (8 * int'(m_fill)));
        col_data_index <= col_data_index + 32'd1;
        if (m_fill == 2'd3) begin
          col_data_out   <= m_next;
          col_data_valid <= 1'b1;
          m_word         <= '0;
          m_fill         <= 2'd0;
        end else begin
          m_word <= m_next;
          m_fill <= m_fill + 2'd1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (wr_valid && wr_ready) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
      end
      if (done) done_cnt = done_cnt + 1;
      if (col_fill_data) flush_cnt = flush_cnt + 1;
    end
  end

  task automatic do_start(input logic [31:0] cnt, input logic [31:0] us, input logic [31:0] base);
    @(negedge clk);
    sample_count      = cnt;
    undersampling_cfg = us;
    base_addr         = base;
    start             = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, expected 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; wr_ready = 1'b1;
    sample_count = '0; undersampling_cfg = '0; base_addr = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, wr_valid, col_rst, col_data_en, col_fill_data, overflow, aborted} !== 8'h00) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {busy, done, wr_valid, col_rst, col_data_en, col_fill_data, overflow, aborted});
    end
    tests++;
    if ({wr_addr, wr_data, words_written, col_undersampling} !== 128'd0) begin
      fails++;
      $display("FAIL reset_words: addr=%h data=%h ww=%h us=%h expected all 0",
               wr_addr, wr_data, words_written, col_undersampling);
    end
    tests++;
    if (dropped_words !== 16'd0) begin
      fails++;
      $display("FAIL reset_dropped: got %0d expected 0", dropped_words);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int s0 = got_data.size();
    int d0 = done_cnt;
    int f0 = flush_cnt;
    do_start(32'd8, 32'd3, 32'h1000);
    tests++;
    if ({col_rst, busy} !== 2'b11) begin
      fails++;
      $display("FAIL basic_clear: col_rst=%0b busy=%0b expected 1 1", col_rst, busy);
    end
    tests++;
    if (col_undersampling !== 32'd3) begin
      fails++;
      $display("FAIL basic_us: got %0d expected 3", col_undersampling);
    end
    @(negedge clk);
    tests++;
    if ({col_rst, col_data_en} !== 2'b01) begin
      fails++;
      $display("FAIL basic_first_en: col_rst=%0b en=%0b expected 0 1", col_rst, col_data_en);
    end
    wait_idle(100, "basic");
    tests++;
    if (got_data.size() - s0 != 2) begin
      fails++;
      $display("FAIL basic_count: got %0d words expected 2", got_data.size() - s0);
    end else begin
      tests++;
      if ({got_addr[s0], got_data[s0], got_addr[s0+1], got_data[s0+1]} !==
          {32'h1000, 32'h13121110, 32'h1004, 32'h17161514}) begin
        fails++;
        $display("FAIL basic_words: got %h:%h %h:%h expected 1000:13121110 1004:17161514",
                 got_addr[s0], got_data[s0], got_addr[s0+1], got_data[s0+1]);
      end
    end
    tests++;
    if (words_written !== 32'd2 || done_cnt - d0 != 1 || flush_cnt - f0 != 0) begin
      fails++;
      $display("FAIL basic_status: ww=%0d done=%0d flush=%0d expected 2 1 0",
               words_written, done_cnt - d0, flush_cnt - f0);
    end
  endtask

  task automatic test_flush();
    int s0 = got_data.size();
    int f0 = flush_cnt;
    do_start(32'd5, 32'd0, 32'h2000);
    wait_idle(100, "flush");
    tests++;
    if (col_data_index !== 32'd8 || flush_cnt == f0) begin
      fails++;
      $display("FAIL flush_index: index=%0d flush_cycles=%0d expected 8 and >0",
               col_data_index, flush_cnt - f0);
    end
    tests++;
    if (got_data.size() - s0 != 2) begin
      fails++;
      $display("FAIL flush_count: got %0d words expected 2", got_data.size() - s0);
    end else begin
      tests++;
      if ({got_addr[s0+1], got_data[s0+1]} !== {32'h2004, 32'h00000014}) begin
        fails++;
        $display("FAIL flush_last: got %h:%h expected 2004:00000014", got_addr[s0+1], got_data[s0+1]);
      end
    end
  endtask

  task automatic test_zero();
    int s0 = got_data.size();
    do_start(32'd0, 32'd0, 32'h4000);
    tests++;
    if (col_rst !== 1'b1) begin
      fails++;
      $display("FAIL zero_clear: col_rst=%0b expected 1", col_rst);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL zero_done: done=%0b expected 1 two cycles after start", done);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || got_data.size() != s0 || words_written !== 32'd0) begin
      fails++;
      $display("FAIL zero_end: busy=%0b writes=%0d ww=%0d expected 0 0 0",
               busy, got_data.size() - s0, words_written);
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    int s0 = got_data.size();
    wr_ready = 1'b0;
    do_start(32'd40, 32'd0, 32'h0);
    while (col_data_index != 32'd40 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    tests++;
    if ({overflow, wr_valid, busy} !== 3'b111 || dropped_words !== EXP_DROPPED) begin
      fails++;
      $display("FAIL ovf_flags: ovf=%0b valid=%0b busy=%0b dropped=%0d expected 1 1 1 %0d",
               overflow, wr_valid, busy, dropped_words, EXP_DROPPED);
    end
    @(negedge clk);
    tests++;
    if ({wr_addr, wr_data} !== {32'h0, 32'h13121110}) begin
      fails++;
      $display("FAIL ovf_hold: got %h:%h expected 00000000:13121110", wr_addr, wr_data);
    end
    wr_ready = 1'b1;
    wait_idle(100, "ovf");
    tests++;
    if (got_data.size() - s0 != 4 || words_written !== 32'd4) begin
      fails++;
      $display("FAIL ovf_count: writes=%0d ww=%0d expected 4 4", got_data.size() - s0, words_written);
    end else begin
      tests++;
      if ({got_addr[s0+3], got_data[s0+3], overflow} !== {32'hC, 32'h1F1E1D1C, 1'b1}) begin
        fails++;
        $display("FAIL ovf_last: got %h:%h ovf=%0b expected 0000000c:1f1e1d1c 1",
                 got_addr[s0+3], got_data[s0+3], overflow);
      end
    end
  endtask

  task automatic test_abort();
    int n = 0;
    int d0 = done_cnt;
    wr_ready = 1'b0;
    do_start(32'd40, 32'd0, 32'h5000);
    tests++;
    if ({overflow, dropped_words} !== 17'd0) begin
      fails++;
      $display("FAIL abort_start_clear: ovf=%0b dropped=%0d expected 0 0", overflow, dropped_words);
    end
    while (!wr_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if ({busy, col_rst, wr_valid, aborted} !== 4'b0101) begin
      fails++;
      $display("FAIL abort_state: busy=%0b col_rst=%0b valid=%0b aborted=%0b expected 0 1 0 1",
               busy, col_rst, wr_valid, aborted);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (col_rst !== 1'b0 || wr_valid !== 1'b0 || done_cnt != d0) begin
      fails++;
      $display("FAIL abort_after: col_rst=%0b valid=%0b done=%0d expected 0 0 0",
               col_rst, wr_valid, done_cnt - d0);
    end
    wr_ready = 1'b1;
  endtask

  task automatic test_rst_in_flush();
    int n = 0;
    int s0, d0;
    wr_ready = 1'b1;
    do_start(32'd5, 32'd7, 32'h6000);
    while (!col_fill_data && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, col_fill_data, col_data_en, col_rst, wr_valid, aborted, overflow} !== 8'h00 ||
        {words_written, wr_addr, col_undersampling} !== 96'd0) begin
      fails++;
      $display("FAIL rst_flush: flags=%b ww=%0d addr=%h us=%0d expected all 0",
               {busy, done, col_fill_data, col_data_en, col_rst, wr_valid, aborted, overflow},
               words_written, wr_addr, col_undersampling);
    end
    @(negedge clk);
    rst = 1'b0;
    s0 = got_data.size();
    d0 = done_cnt;
    do_start(32'd8, 32'd0, 32'h3000);
    wait_idle(100, "rst_rerun");
    tests++;
    if (got_data.size() - s0 != 2 || done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL rerun_count: writes=%0d done=%0d expected 2 1", got_data.size() - s0, done_cnt - d0);
    end else begin
      tests++;
      if ({got_addr[s0], got_data[s0+1]} !== {32'h3000, 32'h17161514}) begin
        fails++;
        $display("FAIL rerun_words: got addr0=%h data1=%h expected 3000 17161514",
                 got_addr[s0], got_data[s0+1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_zero();
    test_overflow();
    test_abort();
    test_rst_in_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
